// File: rtl/i2c_write_ctrl.sv
// I2C write-only slave front end: decodes START/addr/reg/data byte sequences
// from an oversampled bus and issues one-clock register write strobes.
module i2c_write_ctrl #(
  parameter logic [6:0]  DEV_ADDR = 7'h47,
  parameter int unsigned NUM_REGS = 11  // index register is 4 bits, so at most 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scl_in,
  input  logic                sda_in,
  output logic                sda_oe,
  output logic                reg_wr_en,
  output logic [NUM_REGS-1:0] reg_wr_sel,
  output logic [7:0]          reg_wr_data,
  output logic                busy
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ACK_ADDR,
    S_REG,
    S_ACK_REG,
    S_DATA,
    S_ACK_DATA,
    S_WAIT_STOP
  } state_t;

  state_t state, next_state;

  logic [1:0]       scl_sync, sda_sync;
  logic             scl_d, sda_d;
  logic             scl_s, sda_s;
  logic             scl_rise, scl_fall, start_det, stop_det;

  logic [CNT_W-1:0] bit_cnt;
  logic             byte_full;
  logic [7:0]       shift;
  logic [IDX_W-1:0] idx;

  logic             in_byte, byte_end;
  logic             addr_ok, reg_ok, data_ok;
  logic             shift_en, cnt_clr, idx_load, idx_inc;

  logic                sda_oe_nxt, busy_nxt, wr_en_nxt;
  logic [NUM_REGS-1:0] wr_sel_nxt;
  logic [7:0]          wr_data_nxt;

  // Synchronize SCL/SDA into clk domain and keep one delayed copy for edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  assign scl_s    = scl_sync[1];
  assign sda_s    = sda_sync[1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  // START/STOP qualify on the pre-edge SCL so a coincident SCL fall cannot hide them
  assign start_det = sda_d & ~sda_s & scl_d;
  assign stop_det  = ~sda_d & sda_s & scl_d;

  assign in_byte  = (state == S_ADDR) || (state == S_REG) || (state == S_DATA);
  assign byte_end = in_byte && scl_fall && byte_full;
  assign addr_ok  = (shift[7:1] == DEV_ADDR) && !shift[0];
  assign reg_ok   = (shift < 8'(NUM_REGS));
  assign data_ok  = (idx < IDX_W'(NUM_REGS));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state and datapath control; bus conditions override SCL processing
  always_comb begin
    next_state = state;
    shift_en   = 1'b0;
    cnt_clr    = 1'b0;
    idx_load   = 1'b0;
    idx_inc    = 1'b0;

    if (in_byte && scl_rise && !byte_full) shift_en = 1'b1;

    unique case (state)
      S_IDLE, S_WAIT_STOP: ;
      S_ADDR: if (byte_end) next_state = addr_ok ? S_ACK_ADDR : S_WAIT_STOP;
      S_REG: begin
        if (byte_end) begin
          next_state = reg_ok ? S_ACK_REG : S_WAIT_STOP;
          idx_load   = reg_ok;
        end
      end
      S_DATA: if (byte_end) next_state = data_ok ? S_ACK_DATA : S_WAIT_STOP;
      S_ACK_ADDR: begin
        if (scl_fall) begin
          next_state = S_REG;
          cnt_clr    = 1'b1;
        end
      end
      S_ACK_REG: begin
        if (scl_fall) begin
          next_state = S_DATA;
          cnt_clr    = 1'b1;
        end
      end
      S_ACK_DATA: begin
        if (scl_fall) begin
          next_state = S_DATA;
          cnt_clr    = 1'b1;
          idx_inc    = 1'b1;
        end
      end
      default: next_state = S_IDLE;
    endcase

    if (stop_det) begin
      next_state = S_IDLE;
      shift_en   = 1'b0;
      idx_load   = 1'b0;
      idx_inc    = 1'b0;
    end else if (start_det) begin
      next_state = S_ADDR;
      cnt_clr    = 1'b1;
      shift_en   = 1'b0;
      idx_load   = 1'b0;
      idx_inc    = 1'b0;
    end
  end

  // Next values of the registered outputs, aligned with the next state
  always_comb begin
    sda_oe_nxt  = 1'b0;
    busy_nxt    = 1'b0;
    wr_en_nxt   = 1'b0;
    wr_sel_nxt  = '0;
    wr_data_nxt = reg_wr_data;

    sda_oe_nxt = (next_state == S_ACK_ADDR) || (next_state == S_ACK_REG) ||
                 (next_state == S_ACK_DATA);
    busy_nxt   = (next_state != S_IDLE) && (next_state != S_WAIT_STOP);
    wr_en_nxt  = (state == S_DATA) && (next_state == S_ACK_DATA);
    if (wr_en_nxt) begin
      wr_sel_nxt  = NUM_REGS'(1) << idx;
      wr_data_nxt = shift;
    end
  end

  // Bit counter, shift register and register index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      byte_full <= 1'b0;
      shift     <= '0;
      idx       <= '0;
    end else begin
      if (cnt_clr) begin
        bit_cnt   <= '0;
        byte_full <= 1'b0;
      end else if (shift_en) begin
        shift   <= {shift[6:0], sda_s};
        bit_cnt <= bit_cnt + CNT_W'(1);
        if (bit_cnt == CNT_W'(7)) byte_full <= 1'b1;
      end
      if (idx_load)     idx <= shift[IDX_W-1:0];
      else if (idx_inc) idx <= idx + IDX_W'(1);
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_oe      <= 1'b0;
      busy        <= 1'b0;
      reg_wr_en   <= 1'b0;
      reg_wr_sel  <= '0;
      reg_wr_data <= '0;
    end else begin
      sda_oe      <= sda_oe_nxt;
      busy        <= busy_nxt;
      reg_wr_en   <= wr_en_nxt;
      reg_wr_sel  <= wr_sel_nxt;
      reg_wr_data <= wr_data_nxt;
    end
  end

endmodule
